// File: rtl/instr_fetch.sv
// Instruction fetch stage: one IMEM read per instruction into IR, with flush/drain handling and bus timeout.
// Define INSTR_FETCH_MISALIGN_CHK_EN to add the FETCH_FAULT misaligned-PC check.
module instr_fetch #(
  parameter int unsigned TIMEOUT = 255,
  parameter logic [31:0] RST_IR  = 32'h00000013
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] PC,
  output logic        PC_WRITE,
  output logic [31:0] PC_PLUS4,
  input  logic        FLUSH,
  output logic        IMEM_RD,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_RDY,
  input  logic [31:0] IMEM_DOUT,
  output logic [31:0] IR,
  output logic [31:0] IR_PC,
  output logic        IR_VALID,
  input  logic        IR_READY,
`ifdef INSTR_FETCH_MISALIGN_CHK_EN
  output logic        FETCH_FAULT,
`endif
  output logic        BUS_ERR
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_HOLD  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  localparam logic [15:0] CNT_MAX = 16'(TIMEOUT - 1);

  logic [2:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] ir_pc_q, ir_pc_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;
  logic        err_q, err_d;
  logic [15:0] cnt_q, cnt_d;
  logic        pc_wr;
  logic        misalign;
  logic        tmo;

`ifdef INSTR_FETCH_MISALIGN_CHK_EN
  assign misalign = (PC[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign tmo = !IMEM_RDY && (cnt_q == CNT_MAX);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    ir_d    = ir_q;
    ir_pc_d = ir_pc_q;
    valid_d = valid_q;
    fault_d = fault_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    pc_wr   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (FLUSH) begin
          pc_wr = 1'b1;
        end else if (misalign) begin
          state_d = S_HOLD;
          ir_d    = RST_IR;
          ir_pc_d = PC;
          valid_d = 1'b1;
          fault_d = 1'b1;
        end else begin
          state_d = S_REQ;
          addr_d  = PC;
          cnt_d   = '0;
        end
      end
      S_REQ, S_DRAIN: begin
        // An expired request wins over a same-cycle flush: the bus is treated as hung.
        if (tmo) begin
          state_d = S_ERR;
          err_d   = 1'b1;
          valid_d = 1'b0;
        end else if (FLUSH) begin
          pc_wr   = 1'b1;
          ir_d    = RST_IR;
          valid_d = 1'b0;
          state_d = IMEM_RDY ? S_IDLE : S_DRAIN;
          cnt_d   = (state_q == S_REQ) ? 16'd0 : cnt_q + 16'd1;
        end else if (IMEM_RDY) begin
          if (state_q == S_REQ) begin
            pc_wr   = 1'b1;
            ir_d    = IMEM_DOUT;
            ir_pc_d = addr_q;
            valid_d = 1'b1;
            state_d = S_HOLD;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_HOLD: begin
        if (FLUSH) begin
          pc_wr   = 1'b1;
          ir_d    = RST_IR;
          valid_d = 1'b0;
          fault_d = 1'b0;
          state_d = S_IDLE;
        end else if (IR_READY && !fault_q) begin
          if (misalign) begin
            ir_d    = RST_IR;
            ir_pc_d = PC;
            fault_d = 1'b1;
          end else begin
            valid_d = 1'b0;
            addr_d  = PC;
            cnt_d   = '0;
            state_d = S_REQ;
          end
        end
      end
      default: begin
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      ir_q    <= RST_IR;
      ir_pc_q <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ir_q    <= ir_d;
      ir_pc_q <= ir_pc_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign PC_WRITE  = pc_wr && !RST;
  assign PC_PLUS4  = addr_q + 32'd4;
  assign IMEM_RD   = (state_q == S_REQ) || (state_q == S_DRAIN);
  assign IMEM_ADDR = addr_q;
  assign IR        = ir_q;
  assign IR_PC     = ir_pc_q;
  assign IR_VALID  = valid_q;
  assign BUS_ERR   = err_q;
`ifdef INSTR_FETCH_MISALIGN_CHK_EN
  assign FETCH_FAULT = fault_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch: models the PC register and a fixed-latency instruction memory.
module tb_instr_fetch;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] PC = 32'h0;
  logic        PC_WRITE;
  logic [31:0] PC_PLUS4;
  logic        FLUSH = 1'b0;
  logic        IMEM_RD;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_RDY = 1'b0;
  logic [31:0] IMEM_DOUT = 32'h0;
  logic [31:0] IR;
  logic [31:0] IR_PC;
  logic        IR_VALID;
  logic        IR_READY = 1'b0;
  logic        BUS_ERR;
`ifdef INSTR_FETCH_MISALIGN_CHK_EN
  logic        FETCH_FAULT;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int wait_cnt = 0;
  int lat = 1;
  int pcw_cnt = 0;
  bit mem_on = 1'b0;
  logic [31:0] tgt = 32'h0;
  logic        last_pcw = 1'b0;
  logic [31:0] last_p4 = 32'h0;
  logic [31:0] rsp_addr[$];
  int          rsp_cyc[$];

  instr_fetch #(.TIMEOUT(4), .RST_IR(32'h00000013)) dut (
    .CLK(CLK), .RST(RST), .PC(PC), .PC_WRITE(PC_WRITE), .PC_PLUS4(PC_PLUS4),
    .FLUSH(FLUSH), .IMEM_RD(IMEM_RD), .IMEM_ADDR(IMEM_ADDR), .IMEM_RDY(IMEM_RDY),
    .IMEM_DOUT(IMEM_DOUT), .IR(IR), .IR_PC(IR_PC), .IR_VALID(IR_VALID),
    .IR_READY(IR_READY),
`ifdef INSTR_FETCH_MISALIGN_CHK_EN
    .FETCH_FAULT(FETCH_FAULT),
`endif
    .BUS_ERR(BUS_ERR)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h00000100: return 32'h00500093;
      32'h00000104: return 32'h00A00113;
      32'h00000108: return 32'h00F00193;
      32'h000001F0: return 32'hDEADBEEF;
      32'h00000200: return 32'h002081B3;
      default:      return a ^ 32'h13000000;
    endcase
  endfunction

  // One clock: memory answers after `lat` waiting cycles, PC register loads on PC_WRITE.
  task automatic tick();
    logic fl;
    IMEM_RDY  = mem_on && (IMEM_RD === 1'b1) && (wait_cnt >= lat);
    IMEM_DOUT = IMEM_RDY ? mem_word(IMEM_ADDR) : 32'hBAD0BAD0;
    #1;
    last_pcw = PC_WRITE;
    last_p4  = PC_PLUS4;
    fl       = FLUSH;
    if (last_pcw === 1'b1) pcw_cnt++;
    if (IMEM_RDY) begin
      rsp_addr.push_back(IMEM_ADDR);
      rsp_cyc.push_back(cyc);
    end
    if ((IMEM_RD === 1'b1) && !IMEM_RDY) wait_cnt++;
    else wait_cnt = 0;
    @(posedge CLK);
    #1;
    cyc++;
    if (last_pcw === 1'b1) PC = fl ? tgt : last_p4;
  endtask

  task automatic do_reset();
    RST = 1'b1; FLUSH = 1'b0; IR_READY = 1'b0; mem_on = 1'b0;
    tick();
    tick();
    RST = 1'b0;
    wait_cnt = 0;
  endtask

  task automatic test_reset();
    RST = 1'b1; FLUSH = 1'b1; mem_on = 1'b0;
    tick();
    tick();
    checks++; if (last_pcw !== 1'b0) begin failures++; $display("FAIL rst_pcwrite: got %b want 0", last_pcw); end
    FLUSH = 1'b0;
    RST = 1'b0;
    checks++; if (IMEM_RD !== 1'b0) begin failures++; $display("FAIL rst_rd: got %b want 0", IMEM_RD); end
    checks++; if (IMEM_ADDR !== 32'h0) begin failures++; $display("FAIL rst_addr: got %h want 0", IMEM_ADDR); end
    checks++; if (IR !== 32'h00000013) begin failures++; $display("FAIL rst_ir: got %h want 00000013", IR); end
    checks++; if (IR_PC !== 32'h0) begin failures++; $display("FAIL rst_irpc: got %h want 0", IR_PC); end
    checks++; if (IR_VALID !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b want 0", IR_VALID); end
    checks++; if (BUS_ERR !== 1'b0) begin failures++; $display("FAIL rst_buserr: got %b want 0", BUS_ERR); end
`ifdef INSTR_FETCH_MISALIGN_CHK_EN
    checks++; if (FETCH_FAULT !== 1'b0) begin failures++; $display("FAIL rst_fault: got %b want 0", FETCH_FAULT); end
`endif
  endtask

  task automatic test_first_fetch();
    PC = 32'h100; lat = 1; mem_on = 1'b1; IR_READY = 1'b0;
    tick();
    checks++; if (IMEM_RD !== 1'b1) begin failures++; $display("FAIL ff_rd: got %b want 1", IMEM_RD); end
    checks++; if (IMEM_ADDR !== 32'h100) begin failures++; $display("FAIL ff_addr: got %h want 00000100", IMEM_ADDR); end
    tick();
    checks++; if (last_pcw !== 1'b0) begin failures++; $display("FAIL ff_early_pcw: got %b want 0", last_pcw); end
    checks++; if (IR_VALID !== 1'b0) begin failures++; $display("FAIL ff_early_valid: got %b want 0", IR_VALID); end
    tick();
    checks++; if (last_pcw !== 1'b1) begin failures++; $display("FAIL ff_pcw: got %b want 1", last_pcw); end
    checks++; if (last_p4 !== 32'h104) begin failures++; $display("FAIL ff_p4: got %h want 00000104", last_p4); end
    checks++; if (IR !== 32'h00500093) begin failures++; $display("FAIL ff_ir: got %h want 00500093", IR); end
    checks++; if (IR_PC !== 32'h100) begin failures++; $display("FAIL ff_irpc: got %h want 00000100", IR_PC); end
    checks++; if (IR_VALID !== 1'b1) begin failures++; $display("FAIL ff_valid: got %b want 1", IR_VALID); end
    checks++; if (IMEM_RD !== 1'b0) begin failures++; $display("FAIL ff_hold_rd: got %b want 0", IMEM_RD); end
    tick();
    checks++; if (IR_VALID !== 1'b1 || last_pcw !== 1'b0) begin failures++; $display("FAIL ff_hold: got valid=%b pcw=%b want valid=1 pcw=0", IR_VALID, last_pcw); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    rsp_addr.delete(); rsp_cyc.delete(); pcw_cnt = 0;
    PC = 32'h100; lat = 3; mem_on = 1'b1; IR_READY = 1'b1;
    repeat (15) tick();
    IR_READY = 1'b0;
    checks++; if (rsp_addr.size() != 3) begin failures++; $display("FAIL b2b_count: got %0d want 3", rsp_addr.size()); end
    checks++; if (pcw_cnt != 3) begin failures++; $display("FAIL b2b_pcw: got %0d want 3", pcw_cnt); end
    if (rsp_addr.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (rsp_addr[i] !== 32'h100 + 32'(4 * i)) begin failures++; $display("FAIL b2b_addr%0d: got %h want %h", i, rsp_addr[i], 32'h100 + 32'(4 * i)); end
      end
      checks++; if (rsp_cyc[1] - rsp_cyc[0] != 5) begin failures++; $display("FAIL b2b_gap0: got %0d want 5", rsp_cyc[1] - rsp_cyc[0]); end
      checks++; if (rsp_cyc[2] - rsp_cyc[1] != 5) begin failures++; $display("FAIL b2b_gap1: got %0d want 5", rsp_cyc[2] - rsp_cyc[1]); end
    end
    checks++; if (IR !== 32'h00F00193) begin failures++; $display("FAIL b2b_ir: got %h want 00F00193", IR); end
    checks++; if (IR_PC !== 32'h108) begin failures++; $display("FAIL b2b_irpc: got %h want 00000108", IR_PC); end
  endtask

  task automatic test_flush_drain();
    bit seen_bad;
    seen_bad = 1'b0;
    do_reset();
    PC = 32'h1F0; lat = 3; mem_on = 1'b1; IR_READY = 1'b0;
    tick();
    checks++; if (IMEM_ADDR !== 32'h1F0) begin failures++; $display("FAIL fd_addr: got %h want 000001F0", IMEM_ADDR); end
    FLUSH = 1'b1; tgt = 32'h200;
    tick();
    FLUSH = 1'b0;
    checks++; if (last_pcw !== 1'b1) begin failures++; $display("FAIL fd_pcw: got %b want 1", last_pcw); end
    checks++; if (IMEM_RD !== 1'b1 || IMEM_ADDR !== 32'h1F0) begin failures++; $display("FAIL fd_drain_req: got rd=%b addr=%h want rd=1 addr=000001F0", IMEM_RD, IMEM_ADDR); end
    pcw_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (IR === 32'hDEADBEEF || IR_VALID !== 1'b0) seen_bad = 1'b1;
    end
    checks++; if (pcw_cnt != 0) begin failures++; $display("FAIL fd_drain_pcw: got %0d want 0", pcw_cnt); end
    checks++; if (IMEM_RD !== 1'b0 || IR !== 32'h00000013) begin failures++; $display("FAIL fd_idle: got rd=%b ir=%h want rd=0 ir=00000013", IMEM_RD, IR); end
    tick();
    checks++; if (IMEM_RD !== 1'b1 || IMEM_ADDR !== 32'h200) begin failures++; $display("FAIL fd_newreq: got rd=%b addr=%h want rd=1 addr=00000200", IMEM_RD, IMEM_ADDR); end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (IR === 32'hDEADBEEF) seen_bad = 1'b1;
    end
    checks++; if (seen_bad) begin failures++; $display("FAIL fd_discard: got stale IR/valid seen=1 want 0"); end
    checks++; if (IR !== 32'h002081B3 || IR_PC !== 32'h200 || IR_VALID !== 1'b1) begin failures++; $display("FAIL fd_refetch: got ir=%h pc=%h v=%b want 002081B3 00000200 1", IR, IR_PC, IR_VALID); end
  endtask

  task automatic test_flush_with_rdy();
    pcw_cnt = 0;
    IR_READY = 1'b1;
    tick();
    IR_READY = 1'b0; lat = 1;
    checks++; if (IMEM_ADDR !== 32'h204) begin failures++; $display("FAIL fr_addr: got %h want 00000204", IMEM_ADDR); end
    tick();
    FLUSH = 1'b1; tgt = 32'h300;
    tick();
    FLUSH = 1'b0;
    checks++; if (pcw_cnt != 1) begin failures++; $display("FAIL fr_pcw: got %0d want 1", pcw_cnt); end
    checks++; if (IR !== 32'h00000013 || IR_VALID !== 1'b0) begin failures++; $display("FAIL fr_discard: got ir=%h v=%b want 00000013 0", IR, IR_VALID); end
    tick();
    checks++; if (IMEM_ADDR !== 32'h300 || IMEM_RD !== 1'b1) begin failures++; $display("FAIL fr_target: got addr=%h rd=%b want 00000300 1", IMEM_ADDR, IMEM_RD); end
    tick();
    tick();
    checks++; if (IR !== 32'h13000300 || IR_PC !== 32'h300) begin failures++; $display("FAIL fr_fetch: got ir=%h pc=%h want 13000300 00000300", IR, IR_PC); end
    checks++; if (pcw_cnt != 2) begin failures++; $display("FAIL fr_pcw_total: got %0d want 2", pcw_cnt); end
  endtask

  task automatic test_timeout();
    mem_on = 1'b0;
    IR_READY = 1'b1;
    tick();
    IR_READY = 1'b0;
    repeat (3) tick();
    checks++; if (BUS_ERR !== 1'b0 || IMEM_RD !== 1'b1) begin failures++; $display("FAIL to_early: got err=%b rd=%b want 0 1", BUS_ERR, IMEM_RD); end
    tick();
    checks++; if (BUS_ERR !== 1'b1) begin failures++; $display("FAIL to_err: got %b want 1", BUS_ERR); end
    checks++; if (IMEM_RD !== 1'b0 || IR_VALID !== 1'b0) begin failures++; $display("FAIL to_idle: got rd=%b v=%b want 0 0", IMEM_RD, IR_VALID); end
    FLUSH = 1'b1; tgt = 32'h400; pcw_cnt = 0;
    repeat (2) tick();
    FLUSH = 1'b0;
    tick();
    checks++; if (pcw_cnt != 0) begin failures++; $display("FAIL to_flush_pcw: got %0d want 0", pcw_cnt); end
    checks++; if (BUS_ERR !== 1'b1 || IMEM_RD !== 1'b0 || IMEM_ADDR !== 32'h304) begin failures++; $display("FAIL to_absorb: got err=%b rd=%b addr=%h want 1 0 00000304", BUS_ERR, IMEM_RD, IMEM_ADDR); end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checks++; if (BUS_ERR !== 1'b0 || IMEM_ADDR !== 32'h0 || IR !== 32'h00000013 || IR_VALID !== 1'b0) begin failures++; $display("FAIL to_reset: got err=%b addr=%h ir=%h v=%b want 0 0 00000013 0", BUS_ERR, IMEM_ADDR, IR, IR_VALID); end
  endtask

  task automatic test_wrap();
    do_reset();
    PC = 32'hFFFFFFFC; mem_on = 1'b1; lat = 1;
    tick();
    checks++; if (PC_PLUS4 !== 32'h0) begin failures++; $display("FAIL wrap_p4: got %h want 00000000", PC_PLUS4); end
    tick();
    tick();
    checks++; if (last_pcw !== 1'b1 || last_p4 !== 32'h0) begin failures++; $display("FAIL wrap_pcw: got pcw=%b p4=%h want 1 00000000", last_pcw, last_p4); end
    checks++; if (IR !== 32'hECFFFFFC || IR_PC !== 32'hFFFFFFFC) begin failures++; $display("FAIL wrap_ir: got ir=%h pc=%h want ECFFFFFC FFFFFFFC", IR, IR_PC); end
  endtask

`ifdef INSTR_FETCH_MISALIGN_CHK_EN
  task automatic test_misalign();
    do_reset();
    PC = 32'h102; mem_on = 1'b1; lat = 1; pcw_cnt = 0;
    tick();
    checks++; if (IMEM_RD !== 1'b0 || FETCH_FAULT !== 1'b1) begin failures++; $display("FAIL mis_fault: got rd=%b fault=%b want 0 1", IMEM_RD, FETCH_FAULT); end
    checks++; if (IR_VALID !== 1'b1 || IR_PC !== 32'h102 || IR !== 32'h00000013) begin failures++; $display("FAIL mis_ir: got v=%b pc=%h ir=%h want 1 00000102 00000013", IR_VALID, IR_PC, IR); end
    IR_READY = 1'b1;
    repeat (2) tick();
    IR_READY = 1'b0;
    checks++; if (pcw_cnt != 0 || FETCH_FAULT !== 1'b1 || IMEM_RD !== 1'b0) begin failures++; $display("FAIL mis_stuck: got pcw=%0d fault=%b rd=%b want 0 1 0", pcw_cnt, FETCH_FAULT, IMEM_RD); end
    FLUSH = 1'b1; tgt = 32'h104;
    tick();
    FLUSH = 1'b0;
    checks++; if (last_pcw !== 1'b1 || FETCH_FAULT !== 1'b0 || IR_VALID !== 1'b0) begin failures++; $display("FAIL mis_flush: got pcw=%b fault=%b v=%b want 1 0 0", last_pcw, FETCH_FAULT, IR_VALID); end
    tick();
    checks++; if (IMEM_RD !== 1'b1 || IMEM_ADDR !== 32'h104) begin failures++; $display("FAIL mis_resume: got rd=%b addr=%h want 1 00000104", IMEM_RD, IMEM_ADDR); end
    tick();
    tick();
    checks++; if (IR !== 32'h00A00113 || IR_PC !== 32'h104 || FETCH_FAULT !== 1'b0) begin failures++; $display("FAIL mis_fetch: got ir=%h pc=%h fault=%b want 00A00113 00000104 0", IR, IR_PC, FETCH_FAULT); end
  endtask
`endif

  initial begin
    test_reset();
    test_first_fetch();
    test_back_to_back();
    test_flush_drain();
    test_flush_with_rdy();
    test_timeout();
    test_wrap();
`ifdef INSTR_FETCH_MISALIGN_CHK_EN
    test_misalign();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage directly downstream of the program-counter register.
- Takes the current PC, issues one instruction-memory read per instruction, and holds the returned word in an instruction register (IR) for decode.
- Generates the PC write strobe and the PC+4 value that feed back into the PC register.
- Drops in-flight work on a redirect (flush) and detects memory timeouts.

Parameters:
- TIMEOUT, 255: max cycles a request waits for IMEM_RDY before a bus error; range 1..65535.
- RST_IR, 32'h00000013: IR value at reset and after flush (NOP).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- PC  in  32  current program counter from the PC register.
- PC_WRITE  out  1  load strobe to the PC register; combinational.
- PC_PLUS4  out  32  IMEM_ADDR + 4, modulo 2^32; external mux feeds it to PC_Din when FLUSH=0.
- FLUSH  in  1  redirect pulse; the external mux selects the redirect target for PC_Din while it is high.
- IMEM_RD  out  1  memory read request.
- IMEM_ADDR  out  32  registered request address.
- IMEM_RDY  in  1  memory response valid.
- IMEM_DOUT  in  32  memory read data, valid when IMEM_RDY=1.
- IR  out  32  fetched instruction.
- IR_PC  out  32  address IR was fetched from.
- IR_VALID  out  1  IR holds an unconsumed instruction.
- IR_READY  in  1  decode accepts IR this cycle.
- BUS_ERR  out  1  sticky timeout flag.

Behaviour:
- Reset (RST=1 at an edge) has priority over everything and sets:
  - state=IDLE, IMEM_RD=0, IMEM_ADDR=0, IR=RST_IR, IR_PC=0, IR_VALID=0, BUS_ERR=0, timeout counter=0.
  - PC_WRITE is forced 0 while RST=1.
- States: IDLE, REQ, HOLD, DRAIN, ERR.
- IDLE:
  - next edge: IMEM_ADDR<=PC, state<=REQ.
  - FLUSH=1 here: PC_WRITE=1, state stays IDLE one more cycle so the new PC is sampled.
- REQ:
  - IMEM_RD=1; IMEM_ADDR is held stable until IMEM_RDY.
  - IMEM_RDY=1 and FLUSH=0: PC_WRITE=1 the same cycle; edge: IR<=IMEM_DOUT, IR_PC<=IMEM_ADDR, IR_VALID<=1, state<=HOLD.
  - Fetch latency is 1 cycle plus memory latency; PC holds the next address by the time HOLD is entered.
- HOLD:
  - IMEM_RD=0, IR_VALID=1.
  - IR_READY=1: edge: IR_VALID<=0, IMEM_ADDR<=PC, state<=REQ.
  - Back-to-back throughput: one instruction per (2 + memory latency) cycles.
- FLUSH=1 in REQ, HOLD or DRAIN:
  - PC_WRITE=1 that cycle so PC loads the redirect target.
  - edge: IR_VALID<=0, IR<=RST_IR.
  - REQ with IMEM_RDY=0, or DRAIN with IMEM_RDY=0: state<=DRAIN.
  - All other cases: state<=IDLE.
  - FLUSH wins over IR_READY and IMEM_RDY in the same cycle; the response is discarded.
- DRAIN:
  - IMEM_RD=1 with the old address (a request is never withdrawn).
  - IMEM_RDY=1: data discarded, state<=IDLE, PC_WRITE=0.
- Timeout counter:
  - Clears on entry to REQ/DRAIN; increments each REQ/DRAIN cycle with IMEM_RDY=0.
  - On reaching TIMEOUT: BUS_ERR<=1, IMEM_RD<=0, state<=ERR.
- ERR:
  - Absorbing; only RST exits.
  - IR_VALID=0, PC_WRITE=0; FLUSH is ignored.
- PC_PLUS4 wraps: IMEM_ADDR=32'hFFFFFFFC gives 32'h00000000.
- IR_READY while IR_VALID=0 is ignored.

Optional Feature:
- Macro INSTR_FETCH_MISALIGN_CHK_EN.
- When defined:
  - Adds output FETCH_FAULT (1 bit, reset 0).
  - On the IDLE->REQ or HOLD->REQ transition, if PC[1:0]!=0 the request is skipped and the block goes directly to HOLD with IR=RST_IR, IR_PC=PC, IR_VALID=1, FETCH_FAULT=1.
  - PC_WRITE stays 0 and the block stays in HOLD until FLUSH.
  - FETCH_FAULT clears with IR_VALID.
- When undefined: no port; PC[1:0] is passed through to IMEM_ADDR unchecked.

Test Plan:
- Reset, PC=0x100, memory latency 1 returning 0x00500093 -> IMEM_RD at cycle 2, PC_WRITE pulse with PC_PLUS4=0x104, IR=0x00500093, IR_PC=0x100, IR_VALID=1.
- IR_READY held 1, latency 3 -> fetch every 5 cycles; addresses 0x100, 0x104, 0x108 in order; exactly one PC_WRITE per fetch.
- FLUSH during REQ with IMEM_RDY=0, target 0x200 -> state DRAIN; late response 0xDEADBEEF never appears on IR; next request has IMEM_ADDR=0x200.
- FLUSH and IMEM_RDY in the same cycle -> data discarded, IR=0x00000013, one PC_WRITE, next fetch from the target address.
- IMEM_RDY held 0 with TIMEOUT=4 -> BUS_ERR=1 after 4 REQ cycles, IMEM_RD=0; FLUSH has no effect; RST clears everything.
- With INSTR_FETCH_MISALIGN_CHK_EN, PC=0x102 -> no IMEM_RD, FETCH_FAULT=1, IR_VALID=1, IR_PC=0x102; FLUSH to 0x104 -> FETCH_FAULT=0, normal fetch resumes.
